// File: rtl/bcd2bin_seq.sv
// Sequential 4-digit BCD-to-binary converter using reverse double-dabble, one bit per clock.
// Flags malformed BCD digits and results above BIN_LIMIT.
module bcd2bin_seq #(
    parameter int unsigned BIN_LIMIT = 4095
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [15:0] i_bcd,
    output logic        o_busy,
    output logic        o_valid,
    output logic [13:0] o_bin,
    output logic        o_overflow,
    output logic        o_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_SHIFT = 4'd13;

    state_t      state_q, state_d;
    logic [29:0] work_q, work_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [13:0] bin_q, bin_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [29:0] shifted;
    logic [29:0] step;

    // A corrected nibble is >= 8, so subtracting 3 cannot underflow.
    function automatic logic [3:0] fix_digit(input logic [3:0] d);
        return (d >= 4'd8) ? (d - 4'd3) : d;
    endfunction

    function automatic logic digits_ok(input logic [15:0] b);
        logic ok;
        ok = 1'b1;
        for (int n = 0; n < 4; n++) begin
            if (b[n*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    always_comb begin
        shifted = work_q >> 1;
        step    = {fix_digit(shifted[29:26]), fix_digit(shifted[25:22]),
                   fix_digit(shifted[21:18]), fix_digit(shifted[17:14]),
                   shifted[13:0]};
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (digits_ok(i_bcd)) begin
                        work_d  = {i_bcd, 14'd0};
                        cnt_d   = 4'd0;
                        state_d = SHIFT;
                    end else begin
                        bin_d   = 14'd0;
                        ovf_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                work_d = step;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == LAST_SHIFT) begin
                    bin_d   = step[13:0];
                    ovf_d   = (32'(step[13:0]) > BIN_LIMIT);
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_valid    = valid_q;
    assign o_bin      = bin_q;
    assign o_overflow = ovf_q;
    assign o_error    = err_q;

endmodule
